// File: rtl/seven_seg_disp.sv
// rtl/seven_seg_disp.sv - floor number to 7-segment driver; optional floor-change dp indicator under SEVEN_SEG_CHG_DP_EN
module seven_seg_disp #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int CHG_HOLD   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] current_floor,
    output logic [7:0] disp
);

    // XOR mask turning a logical (lit = 1) pattern into the physical drive level
    localparam logic [7:0] POL_MASK = {8{ACTIVE_LOW}};

    logic [6:0] glyph;
    logic       dp_next;

    // Map the floor number to its logical {g..a} segment pattern
    always_comb begin
        glyph = 7'h00;
        case (current_floor)
            2'd0: glyph = 7'h3F;
            2'd1: glyph = 7'h06;
            2'd2: glyph = 7'h5B;
            2'd3: glyph = 7'h4F;
            default: glyph = 7'h00;
        endcase
    end

`ifdef SEVEN_SEG_CHG_DP_EN
    localparam logic [15:0] HOLD_LOAD = 16'(CHG_HOLD);

    logic [1:0]  prev_floor;
    logic [15:0] hold_cnt;
    logic [15:0] hold_next;

    // A floor change reloads the hold; otherwise count down and stop at zero.
    // dp follows the post-update count so it lights on the same edge as the new glyph.
    always_comb begin
        hold_next = hold_cnt;
        if (current_floor != prev_floor) begin
            hold_next = HOLD_LOAD;
        end else if (hold_cnt != 16'd0) begin
            hold_next = hold_cnt - 16'd1;
        end
        dp_next = (hold_next != 16'd0);
    end

    // Remember the last floor seen and the remaining hold cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_floor <= 2'd0;
            hold_cnt   <= 16'd0;
        end else begin
            prev_floor <= current_floor;
            hold_cnt   <= hold_next;
        end
    end
`else
    // Change indicator absent: dp is permanently unlit. The comparison is always
    // false for a legal hold length and only keeps CHG_HOLD referenced.
    localparam bit DP_OFF = (CHG_HOLD < 0);
    assign dp_next = DP_OFF;
`endif

    // Output register: blank on reset, otherwise dp plus glyph at the panel's polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= POL_MASK;
        end else begin
            disp <= POL_MASK ^ {dp_next, glyph};
        end
    end

endmodule

// File: tb/tb_seven_seg_disp.sv
// tb/tb_seven_seg_disp.sv - randomized and directed self-checking bench for seven_seg_disp
module tb_seven_seg_disp;

`ifdef SEVEN_SEG_CHG_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    localparam int HOLD_A = 100;
    localparam int HOLD_B = 7;
    localparam int BIG    = 1 << 20;

    logic       clk;
    logic       rst;
    logic [1:0] floor;
    logic [7:0] disp_a;
    logic [7:0] disp_b;

    int checks;
    int errors;

    // Model state: last floor seen, edges since the last change, blank flag
    logic [1:0] m_last;
    int         m_since;
    bit         m_blank;
    bit         m_valid;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [6:0] gly_tab [4];

    seven_seg_disp #(.ACTIVE_LOW(1'b1), .CHG_HOLD(HOLD_A)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .current_floor (floor),
        .disp          (disp_a)
    );

    seven_seg_disp #(.ACTIVE_LOW(1'b0), .CHG_HOLD(HOLD_B)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .current_floor (floor),
        .disp          (disp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] expected(input bit active_low, input logic [1:0] f,
                                            input bit dp_on, input bit blank);
        logic [7:0] logical;
        logical = blank ? 8'h00 : {dp_on, gly_tab[f]};
        return active_low ? ~logical : logical;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] act,
                       input logic [7:0] exp_dp, input logic [7:0] exp_nodp);
        check(name, act, DP_EN ? exp_dp : exp_nodp);
    endtask

    // Drive inputs, take one edge, advance the model and compare both instances
    task automatic step(input logic r, input logic [1:0] f);
        rst   = r;
        floor = f;
        @(posedge clk);
        if (r) begin
            m_last  = 2'd0;
            m_since = BIG;
            m_blank = 1'b1;
            m_valid = 1'b1;
        end else begin
            m_blank = 1'b0;
            if (f != m_last) m_since = 0;
            else if (m_since < BIG) m_since++;
            m_last = f;
        end
        exp_a = expected(1'b1, f, DP_EN && (m_since < HOLD_A), m_blank);
        exp_b = expected(1'b0, f, DP_EN && (m_since < HOLD_B), m_blank);
        #1;
        if (m_valid) begin
            check("cycle_a", disp_a, exp_a);
            check("cycle_b", disp_b, exp_b);
        end
    endtask

    task automatic run(input int n, input logic [1:0] f);
        for (int i = 0; i < n; i++) step(1'b0, f);
    endtask

    initial begin
        logic [1:0] seq [4];
        logic [7:0] on_dp [4];
        logic [7:0] on_nodp [4];
        logic [1:0] rf;

        gly_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
        seq     = '{2'd1, 2'd0, 2'd3, 2'd2};
        on_dp   = '{8'h79, 8'h40, 8'h30, 8'h24};
        on_nodp = '{8'hF9, 8'hC0, 8'hB0, 8'hA4};
        checks  = 0;
        errors  = 0;
        m_valid = 1'b0;
        m_last  = 2'd0;
        m_since = BIG;
        m_blank = 1'b1;
        rst     = 1'b1;
        floor   = 2'd0;

        // Reset for two edges, then release on floor 0
        step(1'b1, 2'd0);
        step(1'b1, 2'd0);
        check("reset_a", disp_a, 8'hFF);
        check("reset_b", disp_b, 8'h00);
        step(1'b0, 2'd0);
        check("release_f0_a", disp_a, 8'hC0);
        check("release_f0_b", disp_b, 8'h3F);

        // Floors 1,0,3,2 each held 1000 cycles
        for (int i = 0; i < 4; i++) begin
            step(1'b0, seq[i]);
            lit("hold_first", disp_a, on_dp[i], on_nodp[i]);
            run(99, seq[i]);
            lit("hold_last", disp_a, on_dp[i], on_nodp[i]);
            step(1'b0, seq[i]);
            check("hold_after", disp_a, on_nodp[i]);
            run(899, seq[i]);
        end

        // 0 -> 2, then 2 -> 3 forty cycles later extends the hold
        run(200, 2'd0);
        step(1'b0, 2'd2);
        run(39, 2'd2);
        lit("retrig_mid", disp_a, 8'h24, 8'hA4);
        step(1'b0, 2'd3);
        run(99, 2'd3);
        lit("retrig_last", disp_a, 8'h30, 8'hB0);
        step(1'b0, 2'd3);
        check("retrig_after", disp_a, 8'hB0);

        // Reset ten cycles into a hold aborts it
        run(5, 2'd0);
        step(1'b0, 2'd1);
        run(9, 2'd1);
        step(1'b1, 2'd0);
        check("rst_mid_hold", disp_a, 8'hFF);
        step(1'b0, 2'd0);
        check("rst_release", disp_a, 8'hC0);

        // Active-high instance: steady floor 3, then toggle 0/1 every cycle
        run(10, 2'd3);
        check("ah_floor3", disp_b, 8'h4F);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'(i & 1));
            lit("ah_toggle", disp_b, (i & 1) ? 8'h86 : 8'hBF, (i & 1) ? 8'h06 : 8'h3F);
        end

        // First edge after reset with a nonzero floor counts as a change
        step(1'b1, 2'd2);
        step(1'b0, 2'd2);
        lit("post_rst_change", disp_a, 8'h24, 8'hA4);

        // Randomized floors with mostly-steady holds and occasional resets
        rf = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rf = 2'($urandom_range(0, 3));
            step($urandom_range(0, 199) == 0, rf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
